// File: rtl/seq_array_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, WIDTH-cycle latency.
// Optional DIV_ZERO_DETECT_EN: a zero divisor jumps straight to DONE on the accepting edge and raises div_zero.
module seq_array_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH+1:0] w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == LAST_CNT);

  // r_dvd doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_shift >= {2'b00, r_dsr});
  assign w_sub      = w_shift[WIDTH:0] - {1'b0, r_dsr};
  assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
`ifdef DIV_ZERO_DETECT_EN
    if (w_accept && divisor == '0) begin
      w_next = DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic r_div_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_div_zero  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_dvd <= dividend;
      r_dsr <= divisor;
      r_rem <= '0;
      r_cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_div_zero  <= 1'b1;
      end
`endif
    end else if (r_state == RUN) begin
      r_rem <= w_rem_next;
      r_dvd <= w_quo_next;
      r_cnt <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_quotient  <= w_quo_next;
        r_remainder <= w_rem_next[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
        r_div_zero  <= 1'b0;
`endif
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = r_div_zero;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_array_divider.sv
// Directed and random checks of seq_array_divider (WIDTH=8) against plain integer division.
module tb_seq_array_divider;
  localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZDET = 1'b1;
`else
  localparam bit ZDET = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  seq_array_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge showing done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    int lat, busy_n, exp_lat;
    bit z;
    ref_div(a, b, eq, er);
    z = ZDET && (b == 0);
    exp_lat = z ? 0 : W;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
    lat = 0; busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      chk("hold_quotient", 32'(quotient), 32'(prev_q));
      chk("hold_remainder", 32'(remainder), 32'(prev_r));
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_n), 32'(exp_lat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_zero", 32'(div_zero), 32'(z));
    chk("busy_at_done", 32'(busy), 32'(0));
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_hold_q", 32'(quotient), 32'(prev_q));
    chk("idle_hold_r", 32'(remainder), 32'(prev_r));
  endtask

  initial begin
    int e;
    bit seen;
    logic [W-1:0] a, b;
    logic [W-1:0] corner_a [8] = '{255, 255, 0, 0, 1, 254, 128, 255};
    logic [W-1:0] corner_b [8] = '{1, 255, 1, 255, 255, 255, 2, 2};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    prev_q = '0; prev_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_div_zero", 32'(div_zero), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'(busy), 32'(0));

    do_div(100, 7);
    idle_chk();

    // back-to-back: second start issued in the DONE cycle
    do_div(255, 1);
    do_div(5, 9);
    idle_chk();

    do_div(37, 0);
    idle_chk();

    // start during RUN must be ignored
    dividend = 200; divisor = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; e = 0;
    repeat (2) begin @(negedge clk); e++; end
    dividend = 10; divisor = 2; start = 1'b1;
    @(negedge clk);
    e++; start = 1'b0;
    chk("busy_mid_run", 32'(busy), 32'(1));
    while (!done && e < 20) begin @(negedge clk); e++; end
    chk("ignored_start_latency", 32'(e), 32'(W));
    chk("ignored_start_q", 32'(quotient), 32'(66));
    chk("ignored_start_r", 32'(remainder), 32'(2));
    prev_q = 66; prev_r = 2;
    idle_chk();

    // reset in the middle of a RUN
    dividend = 123; divisor = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; e = 0;
    repeat (3) begin @(negedge clk); e++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_busy", 32'(busy), 32'(0));
    chk("midrun_rst_done", 32'(done), 32'(0));
    chk("midrun_rst_q", 32'(quotient), 32'(0));
    chk("midrun_rst_r", 32'(remainder), 32'(0));
    chk("midrun_rst_dz", 32'(div_zero), 32'(0));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrun_rst_no_done", 32'(seen), 32'(0));
    prev_q = '0; prev_r = '0;
    do_div(123, 5);
    idle_chk();

    for (int i = 0; i < 8; i++) begin
      do_div(corner_a[i], corner_b[i]);
    end
    idle_chk();

    for (int i = 0; i < 700; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      do_div(a, b);
      if ($urandom_range(0, 1) == 1) idle_chk();
    end

    do_div(0, 0);
    idle_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
